// File: rtl/timer_irq_ctrl.sv
// rtl/timer_irq_ctrl.sv - memory-mapped 32-bit timer/compare peripheral with interrupt request
//
// Registers (select = addr_i[ADDR_LSB+1:ADDR_LSB]):
//   0 CTRL   : bit0 EN, bit1 AUTO_RELOAD, bit2 IRQ_EN, bits[15:8] PRESC
//   1 CMP    : compare value
//   2 CNT    : counter value
//   3 STATUS : bit0 MATCH (write 1 to clear), bit1 BUSY (read-only)
//
// Ports:
//   clk_i      clock, rising edge
//   rst_i      synchronous active-high reset
//   req_i      bus request (already address-decoded)
//   we_i       write enable
//   addr_i     byte address
//   be_i       write byte enables
//   wdata_i    write data
//   rdata_o    combinational read data (zero when not reading)
//   int_req_o  level interrupt request
//   int_fin_i  interrupt-finished pulse, clears int_req_o and MATCH
//
// Optional feature macro: TIMER_PRESCALER_EN
//   defined   : CTRL.PRESC is writable and a tick occurs every PRESC+1 clocks in RUN
//   undefined : CTRL[15:8] reads zero and a tick occurs every clock in RUN

module timer_irq_ctrl #(
    parameter logic [31:0] RESET_CMP = 32'hFFFF_FFFF,
    parameter int unsigned ADDR_LSB  = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        int_req_o,
    input  logic        int_fin_i
);

    localparam logic [1:0] SEL_CTRL   = 2'd0;
    localparam logic [1:0] SEL_CMP    = 2'd1;
    localparam logic [1:0] SEL_CNT    = 2'd2;
    localparam logic [1:0] SEL_STATUS = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;

    logic        ctrl_en_q;
    logic        ctrl_auto_q;
    logic        ctrl_irq_en_q;
    logic [31:0] cmp_q;
    logic [31:0] cnt_q;
    logic        match_q;
    logic        int_req_q;

    logic [1:0]  sel;
    logic        wr_acc;
    logic        ctrl_wr;
    logic        cmp_wr;
    logic        cnt_wr;
    logic        status_w1c;
    logic        en_wr_val;
    logic        busy;
    logic        tick;
    logic        match_evt;
    logic        oneshot_end;
    logic [31:0] cmp_wr_val;
    logic [31:0] cnt_wr_val;
    logic [31:0] cnt_tick_val;
    logic [31:0] ctrl_rd;
    logic        unused_addr;

    assign sel         = addr_i[ADDR_LSB+1:ADDR_LSB];
    assign unused_addr = ^addr_i;

    assign wr_acc     = req_i & we_i;
    assign ctrl_wr    = wr_acc & (sel == SEL_CTRL);
    assign cmp_wr     = wr_acc & (sel == SEL_CMP) & (|be_i);
    assign cnt_wr     = wr_acc & (sel == SEL_CNT) & (|be_i);
    assign status_w1c = wr_acc & (sel == SEL_STATUS) & be_i[0] & wdata_i[0];

    // EN value a CTRL write leaves behind; an unselected lane keeps the old bit.
    assign en_wr_val = be_i[0] ? wdata_i[0] : ctrl_en_q;

    assign busy = (state_q == ST_RUN);

`ifdef TIMER_PRESCALER_EN
    logic [7:0] presc_q;
    logic [7:0] presc_cnt_q;

    assign tick    = busy & (presc_cnt_q == presc_q);
    assign ctrl_rd = {16'h0, presc_q, 5'h0, ctrl_irq_en_q, ctrl_auto_q, ctrl_en_q};

    // Restarts on every CTRL write so a new PRESC/EN always begins a full period.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            presc_q     <= 8'h0;
            presc_cnt_q <= 8'h0;
        end else begin
            if (ctrl_wr && be_i[1]) begin
                presc_q <= wdata_i[15:8];
            end
            if (ctrl_wr || !busy || tick) begin
                presc_cnt_q <= 8'h0;
            end else begin
                presc_cnt_q <= presc_cnt_q + 8'd1;
            end
        end
    end
`else
    assign tick    = busy;
    assign ctrl_rd = {29'h0, ctrl_irq_en_q, ctrl_auto_q, ctrl_en_q};
`endif

    assign match_evt   = tick & (cnt_q == cmp_q);
    assign oneshot_end = match_evt & ~ctrl_auto_q;

    // The counter wraps silently at 2^32; only equality with CMP is an event.
    assign cnt_tick_val = match_evt ? (ctrl_auto_q ? 32'h0 : cnt_q) : (cnt_q + 32'd1);

    always_comb begin
        cmp_wr_val = cmp_q;
        cnt_wr_val = cnt_q;
        for (int b = 0; b < 4; b++) begin
            if (be_i[b]) begin
                cmp_wr_val[8*b +: 8] = wdata_i[8*b +: 8];
                cnt_wr_val[8*b +: 8] = wdata_i[8*b +: 8];
            end
        end
    end

    // A CTRL write in the same cycle as a one-shot match decides the state;
    // software intent wins over the hardware stop.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (ctrl_wr && en_wr_val) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (ctrl_wr) begin
                    if (!en_wr_val) begin
                        state_d = ST_IDLE;
                    end
                end else if (oneshot_end) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (ctrl_wr) begin
                    state_d = en_wr_val ? ST_RUN : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            ctrl_en_q     <= 1'b0;
            ctrl_auto_q   <= 1'b0;
            ctrl_irq_en_q <= 1'b0;
            cmp_q         <= RESET_CMP;
            cnt_q         <= 32'h0;
            match_q       <= 1'b0;
            int_req_q     <= 1'b0;
        end else begin
            state_q <= state_d;

            if (ctrl_wr && be_i[0]) begin
                ctrl_en_q     <= wdata_i[0];
                ctrl_auto_q   <= wdata_i[1];
                ctrl_irq_en_q <= wdata_i[2];
            end else if (oneshot_end && !ctrl_wr) begin
                ctrl_en_q <= 1'b0;
            end

            if (cmp_wr) begin
                cmp_q <= cmp_wr_val;
            end

            // Bus write beats increment/reload.
            if (cnt_wr) begin
                cnt_q <= cnt_wr_val;
            end else if (tick) begin
                cnt_q <= cnt_tick_val;
            end

            // Set beats clear for both flags.
            if (match_evt) begin
                match_q <= 1'b1;
            end else if (int_fin_i || status_w1c) begin
                match_q <= 1'b0;
            end

            if (match_evt && ctrl_irq_en_q) begin
                int_req_q <= 1'b1;
            end else if (int_fin_i) begin
                int_req_q <= 1'b0;
            end
        end
    end

    assign int_req_o = int_req_q;

    always_comb begin
        rdata_o = 32'h0;
        if (req_i && !we_i) begin
            case (sel)
                SEL_CTRL:   rdata_o = ctrl_rd;
                SEL_CMP:    rdata_o = cmp_q;
                SEL_CNT:    rdata_o = cnt_q;
                SEL_STATUS: rdata_o = {30'h0, busy, match_q};
                default:    rdata_o = 32'h0;
            endcase
        end
    end

endmodule

// File: tb/tb_timer_irq_ctrl.sv
// tb/tb_timer_irq_ctrl.sv - self-checking bench for timer_irq_ctrl

module tb_timer_irq_ctrl;

    localparam logic [1:0] R_CTRL   = 2'd0;
    localparam logic [1:0] R_CMP    = 2'd1;
    localparam logic [1:0] R_CNT    = 2'd2;
    localparam logic [1:0] R_STATUS = 2'd3;

    logic        clk;
    logic        rst;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        int_req;
    logic        int_fin;

    int tests_run;
    int tests_failed;

    timer_irq_ctrl dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .req_i     (req),
        .we_i      (we),
        .addr_i    (addr),
        .be_i      (be),
        .wdata_i   (wdata),
        .rdata_o   (rdata),
        .int_req_o (int_req),
        .int_fin_i (int_fin)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // All stimulus changes happen at the falling edge.
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rd(input logic [1:0] sel, output logic [31:0] d);
        req  = 1'b1;
        we   = 1'b0;
        addr = {28'h0, sel, 2'b00};
        #1;
        d    = rdata;
        req  = 1'b0;
        addr = 32'h0;
    endtask

    task automatic wr(input logic [1:0] sel, input logic [31:0] d, input logic [3:0] b);
        req   = 1'b1;
        we    = 1'b1;
        addr  = {28'h0, sel, 2'b00};
        be    = b;
        wdata = d;
        @(negedge clk);
        req   = 1'b0;
        we    = 1'b0;
        be    = 4'h0;
        wdata = 32'h0;
        addr  = 32'h0;
    endtask

    task automatic fin_pulse();
        int_fin = 1'b1;
        @(negedge clk);
        int_fin = 1'b0;
    endtask

    task automatic clean();
        wr(R_CTRL, 32'h0, 4'hF);
        wr(R_STATUS, 32'h1, 4'h1);
        fin_pulse();
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        rd(R_CTRL, d);
        tests_run++;
        if (d !== 32'h0) begin tests_failed++; $display("FAIL reset_ctrl: got %h expected %h", d, 32'h0); end
        rd(R_CMP, d);
        tests_run++;
        if (d !== 32'hFFFF_FFFF) begin tests_failed++; $display("FAIL reset_cmp: got %h expected %h", d, 32'hFFFF_FFFF); end
        rd(R_CNT, d);
        tests_run++;
        if (d !== 32'h0) begin tests_failed++; $display("FAIL reset_cnt: got %h expected %h", d, 32'h0); end
        rd(R_STATUS, d);
        tests_run++;
        if (d !== 32'h0) begin tests_failed++; $display("FAIL reset_status: got %h expected %h", d, 32'h0); end
        tests_run++;
        if (int_req !== 1'b0) begin tests_failed++; $display("FAIL reset_int_req: got %b expected 0", int_req); end
        // Reads only respond while req is high.
        tests_run++;
        if (rdata !== 32'h0) begin tests_failed++; $display("FAIL idle_rdata: got %h expected 0", rdata); end
    endtask

    task automatic test_auto_reload();
        logic [31:0] d;
        clean();
        wr(R_CMP, 32'd5, 4'hF);
        wr(R_CNT, 32'd0, 4'hF);
        wr(R_CTRL, 32'h7, 4'hF);
        rd(R_CNT, d);
        tests_run++;
        if (d !== 32'd0) begin tests_failed++; $display("FAIL ar_cnt_start: got %h expected 0", d); end
        for (int i = 1; i <= 5; i++) begin
            cyc(1);
            rd(R_CNT, d);
            tests_run++;
            if (d !== i) begin tests_failed++; $display("FAIL ar_cnt_%0d: got %h expected %h", i, d, i); end
            tests_run++;
            if (int_req !== 1'b0) begin tests_failed++; $display("FAIL ar_irq_early_%0d: got %b expected 0", i, int_req); end
        end
        cyc(1);
        rd(R_CNT, d);
        tests_run++;
        if (d !== 32'd0) begin tests_failed++; $display("FAIL ar_reload: got %h expected 0", d); end
        tests_run++;
        if (int_req !== 1'b1) begin tests_failed++; $display("FAIL ar_irq_rise: got %b expected 1", int_req); end
        rd(R_STATUS, d);
        tests_run++;
        if (d !== 32'h3) begin tests_failed++; $display("FAIL ar_status_match: got %h expected 3", d); end
        fin_pulse();
        tests_run++;
        if (int_req !== 1'b0) begin tests_failed++; $display("FAIL ar_irq_fin: got %b expected 0", int_req); end
        rd(R_STATUS, d);
        tests_run++;
        if (d !== 32'h2) begin tests_failed++; $display("FAIL ar_status_fin: got %h expected 2", d); end
        cyc(4);
        tests_run++;
        if (int_req !== 1'b0) begin tests_failed++; $display("FAIL ar_irq_before_second: got %b expected 0", int_req); end
        cyc(1);
        tests_run++;
        if (int_req !== 1'b1) begin tests_failed++; $display("FAIL ar_irq_second: got %b expected 1", int_req); end
        rd(R_CNT, d);
        tests_run++;
        if (d !== 32'd0) begin tests_failed++; $display("FAIL ar_cnt_second: got %h expected 0", d); end
    endtask

    task automatic test_one_shot();
        logic [31:0] d;
        clean();
        wr(R_CMP, 32'd3, 4'hF);
        wr(R_CNT, 32'd0, 4'hF);
        wr(R_CTRL, 32'h5, 4'hF);
        cyc(3);
        rd(R_STATUS, d);
        tests_run++;
        if (d !== 32'h2) begin tests_failed++; $display("FAIL os_status_pre: got %h expected 2", d); end
        cyc(1);
        rd(R_STATUS, d);
        tests_run++;
        if (d !== 32'h1) begin tests_failed++; $display("FAIL os_status_done: got %h expected 1", d); end
        rd(R_CTRL, d);
        tests_run++;
        if (d !== 32'h4) begin tests_failed++; $display("FAIL os_ctrl_en_cleared: got %h expected 4", d); end
        tests_run++;
        if (int_req !== 1'b1) begin tests_failed++; $display("FAIL os_irq: got %b expected 1", int_req); end
        cyc(3);
        rd(R_CNT, d);
        tests_run++;
        if (d !== 32'd3) begin tests_failed++; $display("FAIL os_cnt_hold: got %h expected 3", d); end
        wr(R_STATUS, 32'h1, 4'h1);
        fin_pulse();
        rd(R_STATUS, d);
        tests_run++;
        if (d !== 32'h0) begin tests_failed++; $display("FAIL os_status_cleared: got %h expected 0", d); end
        wr(R_CTRL, 32'h5, 4'hF);
        rd(R_STATUS, d);
        tests_run++;
        if (d !== 32'h2) begin tests_failed++; $display("FAIL os_restart_busy: got %h expected 2", d); end
        cyc(1);
        rd(R_STATUS, d);
        tests_run++;
        if (d !== 32'h1) begin tests_failed++; $display("FAIL os_rematch: got %h expected 1", d); end
        rd(R_CNT, d);
        tests_run++;
        if (d !== 32'd3) begin tests_failed++; $display("FAIL os_rematch_cnt: got %h expected 3", d); end
    endtask

    task automatic test_wrap();
        logic [31:0] d;
        logic [31:0] exp_seq [3];
        exp_seq[0] = 32'hFFFF_FFFF;
        exp_seq[1] = 32'h0;
        exp_seq[2] = 32'h1;
        clean();
        wr(R_CMP, 32'd1, 4'hF);
        wr(R_CNT, 32'hFFFF_FFFE, 4'hF);
        wr(R_CTRL, 32'h1, 4'hF);
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            rd(R_CNT, d);
            tests_run++;
            if (d !== exp_seq[i]) begin tests_failed++; $display("FAIL wrap_cnt_%0d: got %h expected %h", i, d, exp_seq[i]); end
            rd(R_STATUS, d);
            tests_run++;
            if (d !== 32'h2) begin tests_failed++; $display("FAIL wrap_no_event_%0d: got %h expected 2", i, d); end
        end
        cyc(1);
        rd(R_STATUS, d);
        tests_run++;
        if (d !== 32'h1) begin tests_failed++; $display("FAIL wrap_match: got %h expected 1", d); end
        tests_run++;
        if (int_req !== 1'b0) begin tests_failed++; $display("FAIL wrap_irq_disabled: got %b expected 0", int_req); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        clean();
        wr(R_CMP, 32'd2, 4'hF);
        wr(R_CNT, 32'd0, 4'hF);
        wr(R_CTRL, 32'h7, 4'hF);
        cyc(5);
        int_fin = 1'b1;
        cyc(1);
        int_fin = 1'b0;
        rd(R_STATUS, d);
        tests_run++;
        if (d !== 32'h3) begin tests_failed++; $display("FAIL sim_fin_match: got %h expected 3", d); end
        tests_run++;
        if (int_req !== 1'b1) begin tests_failed++; $display("FAIL sim_fin_irq: got %b expected 1", int_req); end
        cyc(2);
        wr(R_STATUS, 32'h1, 4'h1);
        rd(R_STATUS, d);
        tests_run++;
        if (d !== 32'h3) begin tests_failed++; $display("FAIL sim_w1c_match: got %h expected 3", d); end
        tests_run++;
        if (int_req !== 1'b1) begin tests_failed++; $display("FAIL sim_w1c_irq: got %b expected 1", int_req); end
        wr(R_CNT, 32'h10, 4'hF);
        rd(R_CNT, d);
        tests_run++;
        if (d !== 32'h10) begin tests_failed++; $display("FAIL sim_cnt_write: got %h expected 10", d); end
        wr(R_CTRL, 32'h0, 4'hF);
    endtask

    task automatic test_prescaler();
        logic [31:0] d;
        clean();
        wr(R_CMP, 32'd2, 4'hF);
        wr(R_CNT, 32'd0, 4'hF);
`ifdef TIMER_PRESCALER_EN
        wr(R_CTRL, 32'h0000_0301, 4'hF);
        rd(R_CTRL, d);
        tests_run++;
        if (d !== 32'h0000_0301) begin tests_failed++; $display("FAIL presc_ctrl_rd: got %h expected 301", d); end
        cyc(11);
        rd(R_STATUS, d);
        tests_run++;
        if (d !== 32'h2) begin tests_failed++; $display("FAIL presc_pre_match: got %h expected 2", d); end
        cyc(1);
        rd(R_STATUS, d);
        tests_run++;
        if (d !== 32'h1) begin tests_failed++; $display("FAIL presc_match_12: got %h expected 1", d); end
`else
        wr(R_CTRL, 32'h0000_0301, 4'hF);
        rd(R_CTRL, d);
        tests_run++;
        if (d !== 32'h0000_0001) begin tests_failed++; $display("FAIL presc_ro_zero: got %h expected 1", d); end
        cyc(2);
        rd(R_CNT, d);
        tests_run++;
        if (d !== 32'd2) begin tests_failed++; $display("FAIL presc_every_clock: got %h expected 2", d); end
`endif
        wr(R_CTRL, 32'h0, 4'hF);
    endtask

    task automatic test_mid_reset();
        logic [31:0] d;
        clean();
        wr(R_CMP, 32'd100, 4'hF);
        wr(R_CNT, 32'd0, 4'hF);
        wr(R_CTRL, 32'h7, 4'hF);
        cyc(5);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        rd(R_CTRL, d);
        tests_run++;
        if (d !== 32'h0) begin tests_failed++; $display("FAIL mr_ctrl: got %h expected 0", d); end
        rd(R_CMP, d);
        tests_run++;
        if (d !== 32'hFFFF_FFFF) begin tests_failed++; $display("FAIL mr_cmp: got %h expected ffffffff", d); end
        cyc(3);
        rd(R_CNT, d);
        tests_run++;
        if (d !== 32'h0) begin tests_failed++; $display("FAIL mr_cnt: got %h expected 0", d); end
        rd(R_STATUS, d);
        tests_run++;
        if (d !== 32'h0) begin tests_failed++; $display("FAIL mr_status: got %h expected 0", d); end
    endtask

    // Expectations come from tick arithmetic: ticks = clocks/(PRESC+1), first
    // match at tick CMP-CNT0+1, then every CMP+1 ticks when auto-reloading.
    task automatic test_random();
        logic [31:0] d;
        int cmpv, c0, p, k, t, first, ecnt, am;
        int em, ebusy;
        for (int it = 0; it < 12; it++) begin
            cmpv = $urandom_range(0, 15);
            c0   = $urandom_range(0, cmpv);
`ifdef TIMER_PRESCALER_EN
            p    = $urandom_range(0, 3);
`else
            p    = 0;
`endif
            am   = $urandom_range(0, 1);
            k    = $urandom_range(1, 60);
            clean();
            wr(R_CNT, c0, 4'hF);
            wr(R_CMP, cmpv, 4'hF);
            wr(R_CTRL, (p << 8) | (am << 1) | 5, 4'hF);
            cyc(k);
            t     = k / (p + 1);
            first = cmpv - c0 + 1;
            if (t < first)  ecnt = c0 + t;
            else if (am != 0) ecnt = (t - first) % (cmpv + 1);
            else            ecnt = cmpv;
            em    = (t >= first) ? 1 : 0;
            ebusy = (am != 0 || t < first) ? 1 : 0;
            rd(R_CNT, d);
            tests_run++;
            if (d !== ecnt) begin tests_failed++; $display("FAIL rnd_cnt_%0d: got %h expected %h (cmp=%0d c0=%0d p=%0d auto=%0d k=%0d)", it, d, ecnt, cmpv, c0, p, am, k); end
            rd(R_STATUS, d);
            tests_run++;
            if (d !== ((ebusy << 1) | em)) begin tests_failed++; $display("FAIL rnd_status_%0d: got %h expected %h", it, d, (ebusy << 1) | em); end
            tests_run++;
            if (int_req !== em[0]) begin tests_failed++; $display("FAIL rnd_irq_%0d: got %b expected %b", it, int_req, em[0]); end
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst     = 1'b1;
        req     = 1'b0;
        we      = 1'b0;
        addr    = 32'h0;
        be      = 4'h0;
        wdata   = 32'h0;
        int_fin = 1'b0;
        @(negedge clk);
        test_reset();
        test_auto_reload();
        test_one_shot();
        test_wrap();
        test_back_to_back();
        test_prescaler();
        test_mid_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
